process_scheduler: RTL and testbench
====================================

Name: process_scheduler

Overview:
Round-robin context-switch controller for the multiprogrammed MIPS core. It holds a table of resident processes: valid flag, saved PC, and memory base. On a Timer interrupt or a program finish it saves the running context and selects the next ready process. It then presents the resume PC and the instruction/data memory offsets that the PC mux and the Instruction_Memory / Data_Memory offset inputs consume. It runs on the processor clock, beside Timer and UC.

Parameters:
NUM_PROC, 4, number of process slots (power of two, 2..16)
PID_WIDTH, 2, log2(NUM_PROC)
DATA_WIDTH, 32, width of PC and offset words

Ports:
clock  input  1  processor clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
create  input  1  level request to load a new process
create_base  input  DATA_WIDTH  IM/DM base offset of the new process
create_ack  output  1  one-cycle pulse; create accepted this cycle
create_pid  output  PID_WIDTH  slot assigned, valid with create_ack
create_nack  output  1  one-cycle pulse; create refused, table full
interrupt  input  1  quantum expiry pulse from Timer
finish  input  1  running process executed its finish instruction (pulse)
pc_save  input  DATA_WIDTH  PC of the running process, sampled with interrupt
busy  output  1  high in any state other than IDLE
running  output  1  a process is currently dispatched
cur_pid  output  PID_WIDTH  dispatched slot
resume_pc  output  DATA_WIDTH  PC at which the dispatched process continues
im_offset  output  DATA_WIDTH  base of the dispatched process for Instruction_Memory
dm_offset  output  DATA_WIDTH  base of the dispatched process for Data_Memory
switch_done  output  1  one-cycle pulse; new context is on the outputs
no_proc  output  1  one-cycle pulse; scan found nothing, return to BIOS
full  output  1  all slots valid (combinational from the table)

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries valid=0, saved_pc=0, base=0
  - state=IDLE, cur_pid=0, running=0
  - resume_pc, im_offset, dm_offset = 0
  - all pulse outputs = 0
- States: IDLE, SAVE, SCAN, LOAD.
- IDLE, priority order, highest first, evaluated each cycle:
  - finish && running: clear valid[cur_pid], go to SCAN; interrupt in the same cycle is ignored.
  - interrupt && running: go to SAVE.
  - create:
    - full=0: the lowest-index invalid slot gets valid=1, saved_pc=0, base=create_base; create_ack pulses with create_pid. Stay in IDLE.
    - full=1: create_nack pulses; the table is unchanged.
  - !running && any valid: go to SCAN (auto-start after the first create).
- create is ignored in non-IDLE states; no ack and no nack. The requester holds create until it sees ack or nack.
- interrupt or finish while running=0 is ignored.
- SAVE: saved_pc[cur_pid] <= pc_save (value latched at the interrupt cycle), then go to SCAN. Latency is 1 cycle.
- SCAN:
  - Examines one candidate per cycle: idx = (cur_pid + k) mod NUM_PROC, k = 1..NUM_PROC, wrap-around.
  - k=NUM_PROC is the current slot, so a lone valid process re-selects itself.
  - First valid candidate goes to LOAD.
  - All NUM_PROC candidates invalid: running<=0, no_proc pulses, go to IDLE; cur_pid is unchanged.
- LOAD (1 cycle):
  - cur_pid <= idx; resume_pc <= saved_pc[idx]; im_offset = dm_offset <= base[idx]; running <= 1.
  - switch_done pulses in the cycle after LOAD, when the outputs are stable; then return to IDLE.
- Worst-case latency from interrupt to switch_done: 1 (SAVE) + NUM_PROC (SCAN) + 1 (LOAD) + 1 cycles.
- Outputs are registered, and they hold their values between switches.
- Reset mid-operation aborts any state and returns to the reset values; no partial table writes survive.

Test Plan:
- Reset, then create with base=0x100 and hold: create_ack with create_pid=0, then auto-dispatch. switch_done: cur_pid=0, resume_pc=0, im_offset=dm_offset=0x100, running=1.
- Create bases 0x100/0x200/0x300 (pids 0,1,2), pid 0 running; interrupt with pc_save=0x24: 0x24 is stored in slot 0. switch_done: cur_pid=1, resume_pc=0. Second interrupt: cur_pid=2. Third interrupt: wraps to cur_pid=0, resume_pc=0x24.
- Single process pid 0, interrupt with pc_save=0x40: scan re-selects pid 0, resume_pc=0x40, switch_done at cycle t+NUM_PROC+3.
- Two processes, finish while pid 1 runs: slot 1 invalid, dispatch pid 0. Then finish on pid 0: no_proc pulse, running=0, busy=0.
- Fill all 4 slots, then a fifth create: create_nack pulse, full=1, table unchanged. Create held during SCAN: no ack until IDLE.
- Assert reset during SCAN: outputs return to zero immediately, state IDLE, full=0; a subsequent create gets pid 0.

Source files
------------

// File: rtl/process_scheduler.sv
// Round-robin context-switch controller: keeps a table of resident processes and,
// on a timer interrupt or a finish, saves the running context and dispatches the next one.
module process_scheduler #(
    parameter int NUM_PROC   = 4,
    parameter int PID_WIDTH  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  create,
    input  logic [DATA_WIDTH-1:0] create_base,
    output logic                  create_ack,
    output logic [PID_WIDTH-1:0]  create_pid,
    output logic                  create_nack,
    input  logic                  interrupt,
    input  logic                  finish,
    input  logic [DATA_WIDTH-1:0] pc_save,
    output logic                  busy,
    output logic                  running,
    output logic [PID_WIDTH-1:0]  cur_pid,
    output logic [DATA_WIDTH-1:0] resume_pc,
    output logic [DATA_WIDTH-1:0] im_offset,
    output logic [DATA_WIDTH-1:0] dm_offset,
    output logic                  switch_done,
    output logic                  no_proc,
    output logic                  full
);

    localparam int KW = PID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_SCAN,
        ST_LOAD
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_PROC-1:0]   valid_q, valid_d;
    logic [DATA_WIDTH-1:0] saved_pc_q [NUM_PROC];
    logic [DATA_WIDTH-1:0] base_q     [NUM_PROC];
    logic [PID_WIDTH-1:0]  cur_pid_q, cur_pid_d;
    logic [PID_WIDTH-1:0]  sel_q, sel_d;
    logic [KW-1:0]         scan_k_q, scan_k_d;
    logic                  running_q, running_d;
    logic [DATA_WIDTH-1:0] resume_pc_q, resume_pc_d;
    logic [DATA_WIDTH-1:0] offset_q, offset_d;
    logic [DATA_WIDTH-1:0] pc_lat_q, pc_lat_d;
    logic                  switch_done_q, switch_done_d;
    logic                  no_proc_q, no_proc_d;

    // Table write port, driven from the next-state logic.
    logic                  pc_we;
    logic [PID_WIDTH-1:0]  pc_widx;
    logic [DATA_WIDTH-1:0] pc_wdata;
    logic                  base_we;
    logic [PID_WIDTH-1:0]  base_widx;

    logic                  table_full;
    logic                  any_valid;
    logic [PID_WIDTH-1:0]  free_idx;
    logic [PID_WIDTH-1:0]  cand_idx;
    logic                  take_create;

    assign table_full = &valid_q;
    assign any_valid  = |valid_q;
    assign cand_idx   = PID_WIDTH'(cur_pid_q + scan_k_q[PID_WIDTH-1:0]);

    // Lowest-index free slot; scanning downwards lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = PID_WIDTH'(i);
        end
    end

    // Create is only served when no higher-priority IDLE event claims the cycle.
    assign take_create = (state_q == ST_IDLE) && create &&
                         !(running_q && (finish || interrupt));

    always_comb begin
        // NOTE: every _d and write strobe gets a default first, so no path infers a latch.
        state_d       = state_q;
        valid_d       = valid_q;
        cur_pid_d     = cur_pid_q;
        sel_d         = sel_q;
        scan_k_d      = scan_k_q;
        running_d     = running_q;
        resume_pc_d   = resume_pc_q;
        offset_d      = offset_q;
        pc_lat_d      = pc_lat_q;
        switch_done_d = 1'b0;
        no_proc_d     = 1'b0;
        pc_we         = 1'b0;
        pc_widx       = cur_pid_q;
        pc_wdata      = pc_lat_q;
        base_we       = 1'b0;
        base_widx     = free_idx;

        unique case (state_q)
            ST_IDLE: begin
                if (finish && running_q) begin
                    valid_d[cur_pid_q] = 1'b0;
                    scan_k_d           = KW'(1);
                    state_d            = ST_SCAN;
                end else if (interrupt && running_q) begin
                    pc_lat_d = pc_save;
                    state_d  = ST_SAVE;
                end else if (create) begin
                    if (!table_full) begin
                        valid_d[free_idx] = 1'b1;
                        pc_we             = 1'b1;
                        pc_widx           = free_idx;
                        pc_wdata          = '0;
                        base_we           = 1'b1;
                    end
                end else if (!running_q && any_valid) begin
                    scan_k_d = KW'(1);
                    state_d  = ST_SCAN;
                end
            end

            ST_SAVE: begin
                pc_we    = 1'b1;
                scan_k_d = KW'(1);
                state_d  = ST_SCAN;
            end

            ST_SCAN: begin
                if (valid_q[cand_idx]) begin
                    sel_d   = cand_idx;
                    state_d = ST_LOAD;
                end else if (scan_k_q == KW'(NUM_PROC)) begin
                    running_d = 1'b0;
                    no_proc_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    scan_k_d = scan_k_q + KW'(1);
                end
            end

            ST_LOAD: begin
                cur_pid_d     = sel_q;
                resume_pc_d   = saved_pc_q[sel_q];
                offset_d      = base_q[sel_q];
                running_d     = 1'b1;
                switch_done_d = 1'b1;
                state_d       = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            cur_pid_q     <= '0;
            sel_q         <= '0;
            scan_k_q      <= '0;
            running_q     <= 1'b0;
            resume_pc_q   <= '0;
            offset_q      <= '0;
            pc_lat_q      <= '0;
            switch_done_q <= 1'b0;
            no_proc_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q       <= state_d;
            valid_q       <= valid_d;
            cur_pid_q     <= cur_pid_d;
            sel_q         <= sel_d;
            scan_k_q      <= scan_k_d;
            running_q     <= running_d;
            resume_pc_q   <= resume_pc_d;
            offset_q      <= offset_d;
            pc_lat_q      <= pc_lat_d;
            switch_done_q <= switch_done_d;
            no_proc_q     <= no_proc_d;
        end
    end

    // NOTE: the table must be cleared by reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                saved_pc_q[i] <= '0;
                base_q[i]     <= '0;
            end
        end else begin
            if (pc_we)   saved_pc_q[pc_widx] <= pc_wdata;
            if (base_we) base_q[base_widx]   <= create_base;
        end
    end

    assign create_ack  = take_create && !table_full;
    assign create_nack = take_create && table_full;
    assign create_pid  = free_idx;
    assign busy        = (state_q != ST_IDLE);
    assign running     = running_q;
    assign cur_pid     = cur_pid_q;
    assign resume_pc   = resume_pc_q;
    assign im_offset   = offset_q;
    assign dm_offset   = offset_q;
    assign switch_done = switch_done_q;
    assign no_proc     = no_proc_q;
    assign full        = table_full;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: create/dispatch, round-robin, latency,
// finish/no_proc, table-full handling and mid-operation reset.
module tb_process_scheduler;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          create = 1'b0;
    logic [DW-1:0] create_base = '0;
    logic          create_ack;
    logic [PW-1:0] create_pid;
    logic          create_nack;
    logic          interrupt = 1'b0;
    logic          finish = 1'b0;
    logic [DW-1:0] pc_save = '0;
    logic          busy;
    logic          running;
    logic [PW-1:0] cur_pid;
    logic [DW-1:0] resume_pc;
    logic [DW-1:0] im_offset;
    logic [DW-1:0] dm_offset;
    logic          switch_done;
    logic          no_proc;
    logic          full;

    int checks = 0;
    int errors = 0;

    process_scheduler #(.NUM_PROC(NP), .PID_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .create(create), .create_base(create_base),
        .create_ack(create_ack), .create_pid(create_pid), .create_nack(create_nack),
        .interrupt(interrupt), .finish(finish), .pc_save(pc_save),
        .busy(busy), .running(running), .cur_pid(cur_pid), .resume_pc(resume_pc),
        .im_offset(im_offset), .dm_offset(dm_offset),
        .switch_done(switch_done), .no_proc(no_proc), .full(full)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b0;
        create = 1'b0; interrupt = 1'b0; finish = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Holds create until ack or nack is seen, then drops it after that edge.
    task automatic do_create(input logic [DW-1:0] b, output logic acked,
                             output logic nacked, output logic [PW-1:0] pid);
        acked = 1'b0; nacked = 1'b0; pid = '0;
        @(negedge clock);
        create = 1'b1; create_base = b;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (create_ack || create_nack) begin
                acked = create_ack; nacked = create_nack; pid = create_pid;
                break;
            end
        end
        @(posedge clock);
        #1 create = 1'b0;
    endtask

    task automatic pulse_irq(input logic [DW-1:0] pc);
        @(negedge clock);
        interrupt = 1'b1; pc_save = pc;
        @(posedge clock);
        #1 interrupt = 1'b0;
    endtask

    task automatic pulse_finish();
        @(negedge clock);
        finish = 1'b1;
        @(posedge clock);
        #1 finish = 1'b0;
    endtask

    // Counts negedges until switch_done or no_proc; 0 cycles means timeout.
    task automatic wait_event(output int cycles, output logic sd, output logic np);
        cycles = 0; sd = 1'b0; np = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (switch_done || no_proc) begin
                cycles = i; sd = switch_done; np = no_proc;
                break;
            end
        end
    endtask

    task automatic expect_switch(input string name, input logic [PW-1:0] pid,
                                 input logic [DW-1:0] pc, input logic [DW-1:0] off);
        int cyc; logic sd; logic np;
        wait_event(cyc, sd, np);
        checks++;
        if (sd !== 1'b1 || cur_pid !== pid || resume_pc !== pc || im_offset !== off ||
            dm_offset !== off || running !== 1'b1) begin
            errors++;
            $display("FAIL %s: sd=%b pid=%0d pc=%h im=%h dm=%h run=%b, want sd=1 pid=%0d pc=%h off=%h run=1",
                     name, sd, cur_pid, resume_pc, im_offset, dm_offset, running, pid, pc, off);
        end
    endtask

    task automatic expect_create(input string name, input logic [DW-1:0] b,
                                 input logic [PW-1:0] pid);
        logic a; logic n; logic [PW-1:0] p;
        do_create(b, a, n, p);
        checks++;
        if (a !== 1'b1 || n !== 1'b0 || p !== pid) begin
            errors++;
            $display("FAIL %s: ack=%b nack=%b pid=%0d, want ack=1 nack=0 pid=%0d", name, a, n, p, pid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({running, busy, full, switch_done, no_proc, create_ack, create_nack} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: run=%b busy=%b full=%b sd=%b np=%b ack=%b nack=%b, want all 0",
                     running, busy, full, switch_done, no_proc, create_ack, create_nack);
        end
        checks++;
        if (cur_pid !== '0 || resume_pc !== '0 || im_offset !== '0 || dm_offset !== '0) begin
            errors++;
            $display("FAIL reset_values: pid=%0d pc=%h im=%h dm=%h, want 0", cur_pid, resume_pc,
                     im_offset, dm_offset);
        end
    endtask

    task automatic test_first_create();
        expect_create("first_create", 32'h100, 2'd0);
        expect_switch("first_dispatch", 2'd0, 32'h0, 32'h100);
    endtask

    task automatic test_round_robin();
        expect_create("rr_create1", 32'h200, 2'd1);
        expect_create("rr_create2", 32'h300, 2'd2);
        pulse_irq(32'h24);
        expect_switch("rr_to_pid1", 2'd1, 32'h0, 32'h200);
        pulse_irq(32'h50);
        expect_switch("rr_to_pid2", 2'd2, 32'h0, 32'h300);
        pulse_irq(32'h60);
        expect_switch("rr_wrap_pid0", 2'd0, 32'h24, 32'h100);
    endtask

    task automatic test_single_latency();
        int cyc; logic sd; logic np;
        do_reset();
        expect_create("single_create", 32'h100, 2'd0);
        expect_switch("single_dispatch", 2'd0, 32'h0, 32'h100);
        pulse_irq(32'h40);
        wait_event(cyc, sd, np);
        checks++;
        if (cyc != NP + 3 || sd !== 1'b1 || cur_pid !== 2'd0 || resume_pc !== 32'h40) begin
            errors++;
            $display("FAIL single_latency: cycles=%0d sd=%b pid=%0d pc=%h, want cycles=%0d sd=1 pid=0 pc=40",
                     cyc, sd, cur_pid, resume_pc, NP + 3);
        end
    endtask

    task automatic test_finish();
        int cyc; logic sd; logic np;
        do_reset();
        expect_create("fin_create0", 32'h100, 2'd0);
        expect_switch("fin_dispatch0", 2'd0, 32'h0, 32'h100);
        expect_create("fin_create1", 32'h200, 2'd1);
        pulse_irq(32'h10);
        expect_switch("fin_to_pid1", 2'd1, 32'h0, 32'h200);
        pulse_finish();
        expect_switch("fin_back_pid0", 2'd0, 32'h10, 32'h100);
        pulse_finish();
        wait_event(cyc, sd, np);
        checks++;
        if (np !== 1'b1 || sd !== 1'b0 || running !== 1'b0 || busy !== 1'b0 || cur_pid !== 2'd0) begin
            errors++;
            $display("FAIL no_proc: np=%b sd=%b run=%b busy=%b pid=%0d, want np=1 sd=0 run=0 busy=0 pid=0",
                     np, sd, running, busy, cur_pid);
        end
    endtask

    task automatic test_full();
        logic a; logic n; logic [PW-1:0] p;
        bit seen; bit early;
        do_reset();
        for (int i = 0; i < NP; i++) begin
            expect_create("fill_create", DW'(32'h100 * (i + 1)), PW'(i));
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_fill: full=%b, want 1", full);
        end
        do_create(32'h900, a, n, p);
        checks++;
        if (n !== 1'b1 || a !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL create_nack: ack=%b nack=%b full=%b, want ack=0 nack=1 full=1", a, n, full);
        end
        // Auto-start from cur_pid 0 picks slot 1; its base proves the nack left the table alone.
        expect_switch("full_dispatch", 2'd1, 32'h0, 32'h200);

        @(negedge clock);
        finish = 1'b1; create = 1'b1; create_base = 32'h500;
        #1;
        checks++;
        if (create_ack !== 1'b0 || create_nack !== 1'b0) begin
            errors++;
            $display("FAIL create_vs_finish: ack=%b nack=%b, want 0 0", create_ack, create_nack);
        end
        @(posedge clock);
        #1 finish = 1'b0;
        seen = 0; early = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #1;
            if (create_ack && !busy) begin
                seen = 1;
                break;
            end
            if (create_ack || create_nack) early = 1;
        end
        checks++;
        if (!seen || early || create_pid !== 2'd1 || switch_done !== 1'b1 || cur_pid !== 2'd2 ||
            im_offset !== 32'h300) begin
            errors++;
            $display("FAIL create_during_scan: seen=%0d early=%0d pid=%0d sd=%b cur=%0d im=%h, want 1 0 1 1 2 300",
                     seen, early, create_pid, switch_done, cur_pid, im_offset);
        end
        @(posedge clock);
        #1 create = 1'b0;
        @(negedge clock);
        checks++;
        if (full !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL refill: full=%b busy=%b, want full=1 busy=0", full, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        expect_create("mid_create0", 32'h100, 2'd0);
        expect_switch("mid_dispatch0", 2'd0, 32'h0, 32'h100);
        expect_create("mid_create1", 32'h200, 2'd1);
        pulse_irq(32'h20);
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || im_offset !== 32'h100 || full !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_scan: busy=%b im=%h, want busy=1 im=100", busy, im_offset);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({running, busy, full, switch_done, no_proc} !== 5'b0 || cur_pid !== '0 ||
            resume_pc !== '0 || im_offset !== '0 || dm_offset !== '0) begin
            errors++;
            $display("FAIL async_reset: run=%b busy=%b full=%b pid=%0d pc=%h im=%h dm=%h, want all 0",
                     running, busy, full, cur_pid, resume_pc, im_offset, dm_offset);
        end
        @(negedge clock);
        reset = 1'b1;
        expect_create("post_reset_create", 32'h700, 2'd0);
        expect_switch("post_reset_dispatch", 2'd0, 32'h0, 32'h700);
    endtask

    initial begin
        test_reset();
        test_first_create();
        test_round_robin();
        test_single_latency();
        test_finish();
        test_full();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
